// File: rtl/pifo_task_issuer.sv
// Host-facing initiator for one PIFO lane: turns enqueue/dequeue requests into push/pop strobes one cycle after acceptance.
// Readies are combinational; dequeues are credit-limited so the response FWFT buffer can never overflow.
module pifo_task_issuer #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int TREE_NUM  = 4,
    parameter int CNT_W     = 10,
    parameter int RSP_DEPTH = 4,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int DW            = MTW + PTW,
    localparam int OW            = $clog2(RSP_DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enq_valid,
    output logic                     o_enq_ready,
    input  logic [TREE_NUM_BITS-1:0] i_enq_tree_id,
    input  logic [DW-1:0]            i_enq_data,
    input  logic                     i_deq_valid,
    output logic                     o_deq_ready,
    input  logic [TREE_NUM_BITS-1:0] i_deq_tree_id,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [TREE_NUM_BITS-1:0] o_rsp_tree_id,
    output logic [DW-1:0]            o_rsp_data,
    output logic                     o_deq_empty_err,
    output logic                     o_rsp_unexp_err,
    output logic [OW-1:0]            o_outstanding,
    output logic                     o_push,
    output logic                     o_pop,
    output logic [TREE_NUM_BITS-1:0] o_tree_id,
    output logic [DW-1:0]            o_push_data,
    input  logic                     i_task_fifo_full,
    input  logic                     i_is_level0_pop,
    input  logic [TREE_NUM_BITS-1:0] i_tree_id,
    input  logic [DW-1:0]            i_pop_data
);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [CNT_W-1:0]            r_cnt [TREE_NUM];
    logic [OW-1:0]               r_outstanding;
    logic [OW-1:0]               r_rsp_cnt;
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [TREE_NUM_BITS+DW-1:0] r_rsp_mem [RSP_DEPTH];
    logic                        r_rr;
    logic                        r_push;
    logic                        r_pop;
    logic                        r_empty_err;
    logic                        r_unexp_err;
    logic [TREE_NUM_BITS-1:0]    r_tree_id;
    logic [DW-1:0]               r_push_data;

    logic                        w_enq_elig;
    logic                        w_deq_elig;
    logic                        w_credit;
    logic                        w_enq_grant;
    logic                        w_deq_grant;
    logic                        w_deq_hit;
    logic                        w_rsp_wr;
    logic                        w_rsp_rd;
    logic [TREE_NUM_BITS+DW-1:0] w_rsp_head;

    // Credit counts both in-flight pops and parked responses against buffer depth.
    assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_rsp_cnt}) < (OW+1)'(RSP_DEPTH);
    assign w_enq_elig  = i_enq_valid & ~i_task_fifo_full & ~i_rst & (r_cnt[i_enq_tree_id] != '1);
    assign w_deq_elig  = i_deq_valid & ~i_task_fifo_full & ~i_rst & w_credit;
    assign w_enq_grant = w_enq_elig & (~w_deq_elig | ~r_rr);
    assign w_deq_grant = w_deq_elig & (~w_enq_elig | r_rr);
    assign w_deq_hit   = w_deq_grant & (r_cnt[i_deq_tree_id] != '0);
    assign w_rsp_wr    = i_is_level0_pop & (r_outstanding != '0);
    assign w_rsp_rd    = o_rsp_valid & i_rsp_ready;
    assign w_rsp_head  = r_rsp_mem[r_rd_ptr];

    assign o_enq_ready     = w_enq_grant;
    assign o_deq_ready     = w_deq_grant;
    assign o_rsp_valid     = (r_rsp_cnt != '0);
    assign o_rsp_tree_id   = o_rsp_valid ? w_rsp_head[TREE_NUM_BITS+DW-1:DW] : '0;
    assign o_rsp_data      = o_rsp_valid ? w_rsp_head[DW-1:0] : '0;
    assign o_deq_empty_err = r_empty_err;
    assign o_rsp_unexp_err = r_unexp_err;
    assign o_outstanding   = r_outstanding;
    assign o_push          = r_push;
    assign o_pop           = r_pop;
    assign o_tree_id       = r_tree_id;
    assign o_push_data     = r_push_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < TREE_NUM; t++) r_cnt[t] <= '0;
            r_outstanding <= '0;
            r_rsp_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rr          <= 1'b0;
            r_push        <= 1'b0;
            r_pop         <= 1'b0;
            r_empty_err   <= 1'b0;
            r_unexp_err   <= 1'b0;
            r_tree_id     <= '0;
            r_push_data   <= '0;
        end else begin
            r_push      <= w_enq_grant;
            r_pop       <= w_deq_hit;
            r_empty_err <= w_deq_grant & ~w_deq_hit;
            r_tree_id   <= w_enq_grant ? i_enq_tree_id : (w_deq_hit ? i_deq_tree_id : '0);
            r_push_data <= w_enq_grant ? i_enq_data : '0;

            if (w_enq_grant) begin
                r_cnt[i_enq_tree_id] <= r_cnt[i_enq_tree_id] + CNT_W'(1);
            end else if (w_deq_hit) begin
                r_cnt[i_deq_tree_id] <= r_cnt[i_deq_tree_id] - CNT_W'(1);
            end

            if (w_enq_grant | w_deq_grant) r_rr <= ~r_rr;

            case ({w_deq_hit, w_rsp_wr})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (i_is_level0_pop && (r_outstanding == '0)) r_unexp_err <= 1'b1;

            case ({w_rsp_wr, w_rsp_rd})
                2'b10:   r_rsp_cnt <= r_rsp_cnt + OW'(1);
                2'b01:   r_rsp_cnt <= r_rsp_cnt - OW'(1);
                default: r_rsp_cnt <= r_rsp_cnt;
            endcase
            if (w_rsp_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rsp_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rsp_wr) r_rsp_mem[r_wr_ptr] <= {i_tree_id, i_pop_data};
    end

endmodule

// File: tb/tb_pifo_task_issuer.sv
// Scoreboard bench for pifo_task_issuer with a reference model and a simple PIFO lane stand-in.
module tb_pifo_task_issuer;
    localparam int DEPTH  = 4;
    localparam int CNTMAX = 1023;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enq_valid;
    logic        o_enq_ready;
    logic [1:0]  i_enq_tree_id;
    logic [15:0] i_enq_data;
    logic        i_deq_valid;
    logic        o_deq_ready;
    logic [1:0]  i_deq_tree_id;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [1:0]  o_rsp_tree_id;
    logic [15:0] o_rsp_data;
    logic        o_deq_empty_err;
    logic        o_rsp_unexp_err;
    logic [2:0]  o_outstanding;
    logic        o_push;
    logic        o_pop;
    logic [1:0]  o_tree_id;
    logic [15:0] o_push_data;
    logic        i_task_fifo_full;
    logic        i_is_level0_pop;
    logic [1:0]  i_tree_id;
    logic [15:0] i_pop_data;

    pifo_task_issuer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_enq_valid(i_enq_valid), .o_enq_ready(o_enq_ready),
        .i_enq_tree_id(i_enq_tree_id), .i_enq_data(i_enq_data),
        .i_deq_valid(i_deq_valid), .o_deq_ready(o_deq_ready), .i_deq_tree_id(i_deq_tree_id),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_tree_id(o_rsp_tree_id), .o_rsp_data(o_rsp_data),
        .o_deq_empty_err(o_deq_empty_err), .o_rsp_unexp_err(o_rsp_unexp_err),
        .o_outstanding(o_outstanding),
        .o_push(o_push), .o_pop(o_pop), .o_tree_id(o_tree_id), .o_push_data(o_push_data),
        .i_task_fifo_full(i_task_fifo_full), .i_is_level0_pop(i_is_level0_pop),
        .i_tree_id(i_tree_id), .i_pop_data(i_pop_data)
    );

    always #5 i_clk = ~i_clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          m_cnt [4];
    int          m_out;
    bit          m_rr, m_push, m_pop, m_eerr, m_unexp, m_seen_rst;
    logic [18:0] task_q [$];   // {is_pop, tree, data}
    logic [17:0] rsp_q [$];    // {tree, data}
    logic [17:0] pq [$];       // lane contents held by the stand-in
    logic [17:0] res_q [$];    // results waiting to be returned
    bit          pifo_auto;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: compare current outputs, then advance to the state after the next edge.
    always @(negedge i_clk) begin
        bit eg, dg, ge, gd;
        logic [18:0] te;
        logic [17:0] re;
        eg = i_enq_valid && !i_task_fifo_full && !i_rst && (m_cnt[i_enq_tree_id] != CNTMAX);
        dg = i_deq_valid && !i_task_fifo_full && !i_rst && ((m_out + rsp_q.size()) < DEPTH);
        ge = eg && (!dg || !m_rr);
        gd = dg && (!eg || m_rr);
        if (m_seen_rst) begin
            chk_eq("outstanding", o_outstanding, m_out);
            chk_eq("rsp_valid", o_rsp_valid, rsp_q.size() != 0);
            chk_eq("unexp_err", o_rsp_unexp_err, m_unexp);
            chk_eq("push", o_push, m_push);
            chk_eq("pop", o_pop, m_pop);
            chk_eq("deq_empty_err", o_deq_empty_err, m_eerr);
            chk_eq("enq_ready", o_enq_ready, ge);
            chk_eq("deq_ready", o_deq_ready, gd);
            if (o_push || o_pop) begin
                if (task_q.size() == 0) chk_eq("task_unexpected", {o_push, o_pop}, 0);
                else begin
                    te = task_q.pop_front();
                    chk_eq("task_kind", o_pop, te[18]);
                    chk_eq("task_tree", o_tree_id, te[17:16]);
                    chk_eq("task_data", o_push_data, te[15:0]);
                end
            end
            if (o_rsp_valid && i_rsp_ready) begin
                if (rsp_q.size() == 0) chk_eq("rsp_unexpected", o_rsp_valid, 0);
                else begin
                    re = rsp_q.pop_front();
                    chk_eq("rsp_tree", o_rsp_tree_id, re[17:16]);
                    chk_eq("rsp_data", o_rsp_data, re[15:0]);
                end
            end
        end
        if (i_rst) begin
            for (int t = 0; t < 4; t++) m_cnt[t] = 0;
            m_out = 0; m_rr = 0; m_push = 0; m_pop = 0; m_eerr = 0; m_unexp = 0;
            task_q.delete();
            rsp_q.delete();
            m_seen_rst = 1;
        end else begin
            m_push = ge;
            m_pop  = gd && (m_cnt[i_deq_tree_id] > 0);
            m_eerr = gd && (m_cnt[i_deq_tree_id] == 0);
            if (ge) begin
                task_q.push_back({1'b0, i_enq_tree_id, i_enq_data});
                m_cnt[i_enq_tree_id]++;
            end
            if (m_pop) begin
                task_q.push_back({1'b1, i_deq_tree_id, 16'h0000});
                m_cnt[i_deq_tree_id]--;
            end
            if (ge || gd) m_rr = !m_rr;
            if (i_is_level0_pop) begin
                if (m_out > 0) begin
                    rsp_q.push_back({i_tree_id, i_pop_data});
                    m_out--;
                end else m_unexp = 1;
            end
            if (m_pop) m_out++;
        end
    end

    // One clock; the lane stand-in returns each pop's result the cycle after the strobe.
    task automatic tick();
        logic [17:0] e;
        int idx;
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            pq.delete();
            res_q.delete();
            i_is_level0_pop = 1'b0;
        end else begin
            if (pifo_auto) begin
                if (res_q.size() != 0) begin
                    e = res_q.pop_front();
                    i_is_level0_pop = 1'b1;
                    i_tree_id  = e[17:16];
                    i_pop_data = e[15:0];
                end else i_is_level0_pop = 1'b0;
            end
            if (o_push) pq.push_back({o_tree_id, o_push_data});
            if (o_pop) begin
                idx = -1;
                foreach (pq[j]) if (idx < 0 && pq[j][17:16] == o_tree_id) idx = j;
                if (idx >= 0) begin
                    e = pq[idx];
                    pq.delete(idx);
                end else e = {o_tree_id, 16'hDEAD};
                res_q.push_back(e);
            end
        end
    endtask

    task automatic do_enq(input logic [1:0] t, input logic [15:0] d);
        bit done;
        done = 0;
        i_enq_valid = 1'b1; i_enq_tree_id = t; i_enq_data = d;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            done = o_enq_ready;
            tick();
        end
        i_enq_valid = 1'b0;
        chk_eq("enq_accept", done, 1);
    endtask

    task automatic do_deq(input logic [1:0] t);
        bit done;
        done = 0;
        i_deq_valid = 1'b1; i_deq_tree_id = t;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            done = o_deq_ready;
            tick();
        end
        i_deq_valid = 1'b0;
        chk_eq("deq_accept", done, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_enq_valid = 1'b1; i_deq_valid = 1'b1;
        i_enq_tree_id = 2'd0; i_enq_data = 16'h0; i_deq_tree_id = 2'd0;
        i_rsp_ready = 1'b0; i_task_fifo_full = 1'b0;
        i_is_level0_pop = 1'b0; i_tree_id = 2'd0; i_pop_data = 16'h0;
        pifo_auto = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0; i_enq_valid = 1'b0; i_deq_valid = 1'b0; i_rsp_ready = 1'b1;
        tick();

        // Single push then pop on tree 2, result flows back to the host.
        do_enq(2'd2, 16'h0005);
        do_deq(2'd2);
        repeat (4) tick();

        // Contention: both requests held with tree 0 preloaded.
        for (int i = 0; i < 4; i++) do_enq(2'd0, 16'h0040 + 16'(i));
        i_enq_valid = 1'b1; i_deq_valid = 1'b1; i_deq_tree_id = 2'd0;
        for (int i = 0; i < 12; i++) begin
            i_enq_tree_id = (i % 2 == 0) ? 2'd0 : 2'd2;
            i_enq_data    = 16'h0100 + 16'(i);
            tick();
        end
        i_enq_valid = 1'b0; i_deq_valid = 1'b0;
        repeat (6) tick();

        // Lane task FIFO full stalls acceptance.
        i_task_fifo_full = 1'b1;
        i_enq_valid = 1'b1; i_enq_tree_id = 2'd2; i_enq_data = 16'h0777;
        repeat (3) tick();
        i_task_fifo_full = 1'b0;
        tick();
        i_enq_valid = 1'b0;
        repeat (3) tick();

        // Empty-tree dequeue, then a result with nothing outstanding.
        do_deq(2'd1);
        repeat (4) tick();
        pifo_auto = 1'b0;
        i_is_level0_pop = 1'b1; i_tree_id = 2'd1; i_pop_data = 16'hBEEF;
        tick();
        i_is_level0_pop = 1'b0;
        tick();
        pifo_auto = 1'b1;

        // Credit exhaustion with host stalled, then drain.
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) do_enq(2'd3, 16'h0300 + 16'(i));
        i_deq_valid = 1'b1; i_deq_tree_id = 2'd3;
        repeat (12) tick();
        i_rsp_ready = 1'b1;
        repeat (12) tick();
        i_deq_valid = 1'b0;
        repeat (4) tick();

        // Occupancy counter saturation on tree 1.
        i_enq_valid = 1'b1; i_enq_tree_id = 2'd1;
        for (int i = 0; i < CNTMAX + 6; i++) begin
            i_enq_data = 16'(i);
            tick();
        end
        #1;
        chk_eq("enq_ready_saturated", o_enq_ready, 0);
        i_enq_valid = 1'b0;
        do_deq(2'd1);
        repeat (3) tick();
        do_enq(2'd1, 16'hF00D);
        repeat (3) tick();

        // Reset mid-operation with traffic in flight.
        i_rsp_ready = 1'b0;
        do_deq(2'd3);
        do_deq(2'd0);
        i_enq_valid = 1'b1; i_deq_valid = 1'b1;
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0; i_enq_valid = 1'b0; i_deq_valid = 1'b0;
        repeat (3) tick();
        do_enq(2'd0, 16'h0ABC);
        i_rsp_ready = 1'b1;
        do_deq(2'd0);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
